spi_cmd_arbiter: RTL and testbench
==================================

Name: spi_cmd_arbiter

Overview:
- Shares one SPI_driver command port between N_REQ independent requesters, e.g. a PS-configured requester and a hardware scan engine.
- Arbitrates round-robin and latches the winning command onto the driver inputs.
- Generates the new_command pulse, waits for the driver's completion flag or a timeout, and returns a tagged response.
- Sits in the clk (~40 MHz) domain, between the requesters and the driver instance.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- NEW_CMD_CYCLES, 4, cycles drv_new_command is held high per command (1..255).
- TIMEOUT_CYCLES, 65536, cycles allowed from the new_command falling edge to completion before an error is flagged.
- GAP_CYCLES, 8, minimum idle cycles between consecutive commands (0 allowed).

Ports:
- clk  in  1  core clock, same clk as the SPI driver.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester command valid.
- req_ready  out  N_REQ  per-requester accept; a one-hot pulse.
- req_is_write  in  N_REQ  1=write, 0=read.
- req_addr  in  8*N_REQ  write address or start read address; requester i occupies [8i+7:8i].
- req_data  in  8*N_REQ  write data; ignored for reads.
- req_num_regs  in  8*N_REQ  read length; ignored for writes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  $clog2(N_REQ) (min 1)  requester index that owns the response.
- rsp_error  out  1  1=timeout or illegal command; qualified by rsp_valid.
- busy  out  1  high in every state except IDLE.
- drv_new_command  out  1  to driver new_command.
- drv_is_write  out  1  to driver is_write.
- drv_write_register_addr  out  8  to driver.
- drv_write_data  out  8  to driver.
- drv_start_read_register_addr  out  8  to driver.
- drv_num_regs_to_read  out  8  to driver.
- drv_write_complete  in  1  driver write-done flag, level.
- drv_read_complete  in  1  driver read-done flag, level.

Behaviour:
- Reset:
  - All outputs 0; state IDLE; round-robin pointer 0.
  - Reset asserted mid-command aborts the command with no rsp_valid and drops drv_new_command on the next edge.
- States: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE:
  - Arbitrate when any req_valid is set. Search starts at the pointer and moves upward with wrap; the first valid requester k wins.
  - On that edge: pulse req_ready[k] for one cycle; latch k and its command fields into the drv_* registers; set pointer=(k+1) mod N_REQ.
  - Exception: a read with req_num_regs==0 is accepted (req_ready pulse) but goes straight to RESP with error=1; no new_command is driven.
  - Otherwise go to ISSUE.
  - Decision latency: req_valid sampled high -> req_ready high on the following edge (1 cycle).
- ISSUE:
  - drv_new_command=1 for exactly NEW_CMD_CYCLES cycles, then 0, then go to WAIT.
  - drv_* data registers stay stable from ISSUE entry through RESP exit.
- WAIT:
  - Monitor only the flag that matches the command type: write_complete for writes, read_complete for reads.
  - Completion = rising edge (flag=1 this cycle, 0 the previous cycle), edge-detect register updated every cycle.
  - A flag already high on WAIT entry is NOT completion. A flag that rises in the same cycle WAIT is entered counts.
  - Timeout counter: cleared on WAIT entry, +1 per cycle. When it equals TIMEOUT_CYCLES-1 without completion -> RESP with error=1.
  - Completion and timeout in the same cycle -> completion wins, error=0.
- RESP:
  - One cycle: rsp_valid=1, rsp_id=latched k, rsp_error as determined.
  - Then go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP:
  - Count GAP_CYCLES cycles, then IDLE. req_ready stays 0 throughout.
- req_valid de-asserted before it is granted is legal; no request is latched.
- Requester data are only sampled on the grant edge.
- Counter widths: $clog2 of the parameter, at least 1 bit.
- No combinational path from req_* to drv_*; all drv_* and rsp_* outputs are registered.
- Back-to-back throughput per command: 1 + NEW_CMD_CYCLES + wait + 1 + GAP_CYCLES cycles.

Test Plan:
1. Single write: req0 write addr=0x12 data=0xA5 -> req_ready[0] 1 cycle later; drv_new_command high 4 cycles; pulse write_complete 20 cycles later -> rsp_valid, rsp_id=0, rsp_error=0; busy low after 8 GAP cycles.
2. Round robin: req0 and req1 held valid continuously, each completing after 10 cycles -> grant order 0,1,0,1; no requester granted twice in a row.
3. Timeout: TIMEOUT_CYCLES=100, read num_regs=4 with no read_complete -> rsp_error=1 exactly 100 cycles after new_command falls; next request is then served normally.
4. Stale flag: write_complete already high before the grant, then low, then pulsed -> only the later rising edge completes; the stale level is ignored.
5. Illegal read: req1 read num_regs=0 -> req_ready[1] pulse, drv_new_command never rises, rsp_valid with id=1, error=1.
6. Reset mid-WAIT: assert rst for 1 cycle while waiting -> all outputs 0 next cycle, no rsp_valid; pending req0 then granted first (pointer=0).

Source files
------------

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing one SPI driver command port between N_REQ requesters.
// Issues new_command, waits for the matching completion edge or a timeout, then returns a tagged response.
module spi_cmd_arbiter #(
    parameter int N_REQ          = 2,
    parameter int NEW_CMD_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int GAP_CYCLES     = 8,
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ-1:0]   req_is_write,
    input  logic [8*N_REQ-1:0] req_addr,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [8*N_REQ-1:0] req_num_regs,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic               rsp_error,
    output logic               busy,
    output logic               drv_new_command,
    output logic               drv_is_write,
    output logic [7:0]         drv_write_register_addr,
    output logic [7:0]         drv_write_data,
    output logic [7:0]         drv_start_read_register_addr,
    output logic [7:0]         drv_num_regs_to_read,
    input  logic               drv_write_complete,
    input  logic               drv_read_complete
);

    localparam int IW = (NEW_CMD_CYCLES > 1) ? $clog2(NEW_CMD_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [IW-1:0] ISSUE_LAST = IW'(NEW_CMD_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} state_t;
    state_t state, state_n;

    logic [IDW-1:0] ptr, grant_id;
    logic [IDW:0]   cand;
    logic           found, illegal, grant, done, timeout, flag, flag_q;
    logic           wc_q, rc_q;
    logic [IW-1:0]  issue_cnt;
    logic [TW-1:0]  to_cnt;
    logic [GW-1:0]  gap_cnt;

    logic [7:0] addr_a [N_REQ];
    logic [7:0] data_a [N_REQ];
    logic [7:0] nreg_a [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[8*i +: 8];
        assign data_a[i] = req_data[8*i +: 8];
        assign nreg_a[i] = req_num_regs[8*i +: 8];
    end

    // Rotating priority search: first valid requester at or above ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        cand     = '0;
        for (int j = 0; j < N_REQ; j++) begin
            cand = {1'b0, ptr} + (IDW+1)'(j);
            if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found    = 1'b1;
                grant_id = cand[IDW-1:0];
            end
        end
    end

    assign illegal = !req_is_write[grant_id] && (nreg_a[grant_id] == 8'd0);
    assign flag    = drv_is_write ? drv_write_complete : drv_read_complete;
    assign flag_q  = drv_is_write ? wc_q : rc_q;
    assign done    = flag & ~flag_q;
    assign timeout = (to_cnt == TO_LAST);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        case (state)
            IDLE:  if (found) begin
                       grant   = 1'b1;
                       state_n = illegal ? RESP : ISSUE;
                   end
            ISSUE: if (issue_cnt == ISSUE_LAST) state_n = WAIT;
            WAIT:  if (done || timeout) state_n = RESP;
            RESP:  state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:   if (gap_cnt == GAP_LAST) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr                          <= '0;
            req_ready                    <= '0;
            rsp_valid                    <= 1'b0;
            rsp_id                       <= '0;
            rsp_error                    <= 1'b0;
            drv_new_command              <= 1'b0;
            drv_is_write                 <= 1'b0;
            drv_write_register_addr      <= '0;
            drv_write_data               <= '0;
            drv_start_read_register_addr <= '0;
            drv_num_regs_to_read         <= '0;
            wc_q                         <= 1'b0;
            rc_q                         <= 1'b0;
            issue_cnt                    <= '0;
            to_cnt                       <= '0;
            gap_cnt                      <= '0;
        end else begin
            wc_q      <= drv_write_complete;
            rc_q      <= drv_read_complete;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            if (grant) begin
                req_ready[grant_id]          <= 1'b1;
                rsp_id                       <= grant_id;
                ptr                          <= (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                drv_is_write                 <= req_is_write[grant_id];
                drv_write_register_addr      <= addr_a[grant_id];
                drv_start_read_register_addr <= addr_a[grant_id];
                drv_write_data               <= data_a[grant_id];
                drv_num_regs_to_read         <= nreg_a[grant_id];
                drv_new_command              <= !illegal;
                issue_cnt                    <= '0;
                // Zero-length read is answered immediately without touching the driver.
                if (illegal) begin
                    rsp_valid <= 1'b1;
                    rsp_error <= 1'b1;
                end
            end
            case (state)
                ISSUE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == ISSUE_LAST) begin
                        drv_new_command <= 1'b0;
                        to_cnt          <= '0;
                    end
                end
                WAIT: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (done || timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_error <= !done;
                    end
                end
                RESP: gap_cnt <= '0;
                GAP:  gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Randomized bench for spi_cmd_arbiter: a round-robin reference model predicts grants and responses,
// a monitor pops expected responses from a queue whenever rsp_valid is presented.
module tb_spi_cmd_arbiter;

    localparam int N   = 3;
    localparam int NC  = 4;
    localparam int TO  = 100;
    localparam int GP  = 8;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0, req_ready, req_is_write = '0;
    logic [8*N-1:0] req_addr = '0, req_data = '0, req_num_regs = '0;
    logic           rsp_valid, rsp_error, busy;
    logic [IDW-1:0] rsp_id;
    logic           drv_new_command, drv_is_write;
    logic [7:0]     drv_write_register_addr, drv_write_data;
    logic [7:0]     drv_start_read_register_addr, drv_num_regs_to_read;
    logic           drv_write_complete = 1'b0, drv_read_complete = 1'b0;

    spi_cmd_arbiter #(.N_REQ(N), .NEW_CMD_CYCLES(NC), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GP)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_write(req_is_write),
        .req_addr(req_addr), .req_data(req_data), .req_num_regs(req_num_regs),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_error(rsp_error), .busy(busy),
        .drv_new_command(drv_new_command), .drv_is_write(drv_is_write),
        .drv_write_register_addr(drv_write_register_addr), .drv_write_data(drv_write_data),
        .drv_start_read_register_addr(drv_start_read_register_addr),
        .drv_num_regs_to_read(drv_num_regs_to_read),
        .drv_write_complete(drv_write_complete), .drv_read_complete(drv_read_complete)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: pending commands per requester plus the rotating priority pointer.
    bit         pend [N];
    bit         m_wr [N];
    logic [7:0] m_addr [N], m_data [N], m_nr [N];
    int         ptr = 0;

    typedef struct { int id; bit err; } exp_t;
    exp_t expq [$];

    function automatic bit anypend();
        bit a = 0;
        for (int i = 0; i < N; i++) a |= pend[i];
        return a;
    endfunction

    task automatic add_req(input int i, input bit wr, input logic [7:0] a, input logic [7:0] d, input logic [7:0] nr);
        pend[i] = 1; m_wr[i] = wr; m_addr[i] = a; m_data[i] = d; m_nr[i] = nr;
        req_valid[i] = 1'b1;
        req_is_write[i] = wr;
        req_addr[8*i +: 8] = a;
        req_data[8*i +: 8] = d;
        req_num_regs[8*i +: 8] = nr;
    endtask

    task automatic setflag(input bit wr, input bit v);
        if (wr) drv_write_complete = v;
        else    drv_read_complete  = v;
    endtask

    // mode 0: complete after d cycles; 1: no completion (timeout);
    // 2: wrong flag pulsed first, then right flag; 3: stale level before grant, later real edge.
    task automatic serve(input int mode, input int d, output int k);
        bit ill, err;
        int t, hc, c;
        logic [63:0] fields;
        k = -1;
        for (int j = 0; j < N; j++)
            if (k < 0 && pend[(ptr + j) % N]) k = (ptr + j) % N;
        if (k < 0) return;
        ill = !m_wr[k] && (m_nr[k] == 8'd0);
        err = ill || (mode == 1);
        if (mode == 3) setflag(m_wr[k], 1'b1);
        expq.push_back('{k, err});
        pend[k] = 0;
        ptr = (k + 1) % N;

        t = 0;
        do begin @(negedge clk); t++; end while (req_ready == '0 && t < 20);
        chk("grant_latency", t, 1);
        chk("req_ready", req_ready, 64'(1) << k);
        req_valid[k] = 1'b0;
        chk("drv_is_write", drv_is_write, m_wr[k]);
        if (m_wr[k]) begin
            chk("drv_wr_addr", drv_write_register_addr, m_addr[k]);
            chk("drv_wr_data", drv_write_data, m_data[k]);
            fields = {drv_write_register_addr, drv_write_data};
        end else begin
            chk("drv_rd_addr", drv_start_read_register_addr, m_addr[k]);
            chk("drv_num_regs", drv_num_regs_to_read, m_nr[k]);
            fields = {drv_start_read_register_addr, drv_num_regs_to_read};
        end
        chk("new_cmd_at_grant", drv_new_command, !ill);

        if (!ill) begin
            hc = 0;
            while (drv_new_command === 1'b1 && hc < 300) begin hc++; @(negedge clk); end
            chk("new_cmd_cycles", hc, NC);
            case (mode)
                1: begin
                    c = 0;
                    while (rsp_valid !== 1'b1 && c < 300) begin @(negedge clk); c++; end
                    chk("timeout_cycles", c, TO);
                end
                2: begin
                    setflag(!m_wr[k], 1'b1);
                    @(negedge clk) setflag(!m_wr[k], 1'b0);
                    repeat (d) @(negedge clk);
                    setflag(m_wr[k], 1'b1);
                    @(negedge clk) setflag(m_wr[k], 1'b0);
                    chk("rsp_after_edge", rsp_valid, 1);
                end
                3: begin
                    repeat (3) @(negedge clk);
                    setflag(m_wr[k], 1'b0);
                    repeat (2) @(negedge clk);
                    setflag(m_wr[k], 1'b1);
                    @(negedge clk) setflag(m_wr[k], 1'b0);
                    chk("rsp_after_edge", rsp_valid, 1);
                end
                default: begin
                    repeat (d) @(negedge clk);
                    setflag(m_wr[k], 1'b1);
                    @(negedge clk) setflag(m_wr[k], 1'b0);
                    chk("rsp_after_edge", rsp_valid, 1);
                end
            endcase
        end

        t = 0;
        while (rsp_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        chk("rsp_seen", rsp_valid, 1);
        chk("drv_stable", m_wr[k] ? {drv_write_register_addr, drv_write_data}
                                  : {drv_start_read_register_addr, drv_num_regs_to_read}, fields);
        t = 0;
        do begin @(negedge clk); t++; end while (busy !== 1'b0 && t < 50);
        chk("gap_cycles", t, GP + 1);
    endtask

    // Monitor: every presented response must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got id=%0d with nothing outstanding", rsp_id);
                end else begin
                    e = expq.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_error", rsp_error, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    function automatic logic [63:0] outs();
        return {req_ready, rsp_valid, rsp_id, rsp_error, busy, drv_new_command, drv_is_write,
                drv_write_register_addr, drv_write_data, drv_start_read_register_addr, drv_num_regs_to_read};
    endfunction

    initial begin
        int k, r, mode, t;
        bit wr;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst = 1'b0;

        // single write
        add_req(0, 1, 8'h12, 8'hA5, 8'h00);
        serve(0, 20, k);

        // two requesters held valid continuously
        add_req(0, 1, 8'h01, 8'h11, 8'h00);
        add_req(1, 0, 8'h02, 8'h00, 8'h03);
        repeat (4) begin
            serve(0, 10, k);
            add_req(k, m_wr[k], m_addr[k] + 8'h1, m_data[k], m_nr[k]);
        end
        while (anypend()) serve(0, 3, k);

        // timeout then a normal command
        add_req(1, 0, 8'h40, 8'h00, 8'd4);
        serve(1, 0, k);
        add_req(0, 1, 8'h41, 8'h5A, 8'h00);
        serve(0, 5, k);

        // stale completion level
        add_req(2, 1, 8'h77, 8'hC3, 8'h00);
        serve(3, 0, k);

        // zero-length read
        add_req(1, 0, 8'h55, 8'h00, 8'h00);
        serve(0, 0, k);

        // reset while waiting: aborted command gets no response, pointer returns to 0
        add_req(0, 1, 8'h33, 8'h44, 8'h00);
        pend[0] = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (req_ready == '0 && t < 20);
        chk("rst_test_grant", req_ready, 1);
        req_valid[0] = 1'b0;
        t = 0;
        while (drv_new_command === 1'b1 && t < 50) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        add_req(1, 1, 8'h66, 8'h01, 8'h00);
        add_req(0, 0, 8'h67, 8'h00, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_wait", outs(), 0);
        rst = 1'b0;
        ptr = 0;
        serve(0, 4, k);
        while (anypend()) serve(0, 2, k);

        // randomized traffic
        repeat (40) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    wr = 1'($urandom_range(0, 1));
                    add_req(i, wr, 8'($urandom), 8'($urandom),
                            ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255)));
                end
            if (!anypend()) add_req(0, 1, 8'($urandom), 8'($urandom), 8'd0);
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : (r < 8) ? 1 : 2;
            serve(mode, $urandom_range(0, 20), k);
        end
        while (anypend()) serve(0, 1, k);

        repeat (5) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
